// File: rtl/maze_path_player.sv
// Replays a solved maze path: drains the solver's direction stack into a LIFO
// buffer, then emits the moves start-to-goal over a valid/ready handshake.
module maze_path_player #(
  parameter int DEPTH = 256,
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic             fs_empty,
  input  logic [1:0]       fs_data,
  output logic             fs_pop,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [1:0]       Move,
  output logic [LEN_W-1:0] path_len,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] FULL = LEN_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, POP, CAPTURE, PLAY, DONE, ERR} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] wr_ptr, wr_nxt, len_nxt, rd_ptr;
  logic             start_q, start_rise;
  logic [1:0]       movebuf [DEPTH];

  assign start_rise = start & ~start_q;
  assign rd_ptr     = wr_ptr - LEN_W'(1);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      path_len <= '0;
      start_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_nxt;
      path_len <= len_nxt;
      start_q  <= start;
    end
  end

  // Storage needs no reset; entries are only read below the write pointer.
  always_ff @(posedge clk) begin
    if (state == CAPTURE)
      movebuf[wr_ptr[AW-1:0]] <= fs_data;
  end

  always_comb begin
    state_nxt  = state;
    wr_nxt     = wr_ptr;
    len_nxt    = path_len;
    fs_pop     = 1'b0;
    move_valid = 1'b0;
    Move       = 2'b00;
    busy       = 1'b0;
    done       = 1'b0;
    ovf        = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_nxt = POP;
          wr_nxt    = '0;
          len_nxt   = '0;
        end
      end
      POP: begin
        busy = 1'b1;
        if (fs_empty) begin
          len_nxt   = wr_ptr;
          state_nxt = (wr_ptr == '0) ? DONE : PLAY;
        end else if (wr_ptr == FULL) begin
          len_nxt   = wr_ptr;
          state_nxt = ERR;
        end else begin
          fs_pop    = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        busy      = 1'b1;
        wr_nxt    = wr_ptr + LEN_W'(1);
        state_nxt = POP;
      end
      // Reading from the top of the buffer restores the original move order.
      PLAY: begin
        busy       = 1'b1;
        move_valid = 1'b1;
        Move       = movebuf[rd_ptr[AW-1:0]];
        if (move_ready) begin
          wr_nxt = rd_ptr;
          if (wr_ptr == LEN_W'(1))
            state_nxt = DONE;
        end
      end
      DONE, ERR: begin
        done = (state == DONE);
        ovf  = (state == ERR);
        if (start_rise) begin
          state_nxt = POP;
          wr_nxt    = '0;
          len_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_maze_path_player.sv
// Randomized bench for maze_path_player: a queue-based direction stack feeds the
// DUT and the replayed moves are compared against the stack's bottom-to-top order.
module tb_maze_path_player;

  localparam int DEPTH = 4;
  localparam int LEN_W = 3;

  logic             clk = 1'b0;
  logic             RST, start, fs_empty, move_ready;
  logic [1:0]       fs_data;
  logic             fs_pop, move_valid, busy, done, ovf;
  logic [1:0]       Move;
  logic [LEN_W-1:0] path_len;

  int   errors = 0;
  int   checks = 0;
  int   popCount = 0;
  int   violations = 0;
  logic emptyPending = 1'b0;
  logic prevPop = 1'b0;
  logic [1:0] stack[$];

  maze_path_player #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .RST(RST), .start(start), .fs_empty(fs_empty), .fs_data(fs_data),
    .fs_pop(fs_pop), .move_valid(move_valid), .move_ready(move_ready), .Move(Move),
    .path_len(path_len), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle; the stack answers a pop with data for the following cycle
  // and updates its empty flag one cycle later, as a registered stack would.
  task automatic tick();
    @(negedge clk);
    if (emptyPending) begin
      fs_empty     = (stack.size() == 0);
      emptyPending = 1'b0;
    end
    if (fs_pop) begin
      if (fs_empty || prevPop || !busy) violations++;
      else begin
        fs_data = stack.pop_back();
        popCount++;
        emptyPending = 1'b1;
      end
    end
    prevPop = fs_pop;
    if (!move_valid && Move != 2'b00) violations++;
  endtask

  task automatic loadStack(input int n);
    for (int i = 0; i < n; i++) stack.push_back(2'($urandom_range(0, 3)));
    fs_empty = (stack.size() == 0);
  endtask

  // mode 0: always ready, 1: ready pattern 0,0,1, 2: random ready
  task automatic applyStimulus(input int mode, input bit holdStart, input int stopAfter);
    logic [1:0] expq[$];
    logic [1:0] prevMove;
    int n, k, lat, idx, budget, cyc;
    bit held, rdy;
    expq = stack;
    n = stack.size();
    k = (n > DEPTH) ? DEPTH : n;
    popCount = 0;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    lat = 1;
    checkOutput("busyAfterStart", {busy, done, ovf}, 3'b100);
    if (!holdStart) start = 1'b0;
    move_ready = 1'($urandom_range(0, 1));
    while (!(move_valid || done || ovf) && lat < 100) begin
      tick();
      lat++;
      move_ready = 1'($urandom_range(0, 1));
    end
    checkOutput("latency", lat, 2 * k + 2);
    checkOutput("popCount", popCount, k);
    checkOutput("pathLen", path_len, k);
    if (n > DEPTH) begin
      checkOutput("errState", {ovf, done, busy, fs_pop, move_valid}, 5'b10000);
      return;
    end
    if (n == 0) begin
      checkOutput("emptyDone", {done, move_valid, busy}, 3'b100);
      return;
    end
    idx = 0; budget = 0; cyc = 0; held = 1'b0; prevMove = 2'b00;
    while (idx < n && idx != stopAfter && budget < 200) begin
      if (move_valid) begin
        if (held && Move !== prevMove) violations++;
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
        cyc++;
        if (rdy) begin
          checkOutput($sformatf("move%0d", idx), Move, expq[idx]);
          idx++;
        end
        held = !rdy;
        prevMove = Move;
        move_ready = rdy;
      end else begin
        violations++;
        move_ready = 1'b0;
      end
      tick();
      budget++;
    end
    if (stopAfter >= 0 && idx == stopAfter) return;
    checkOutput("playCount", idx, n);
    move_ready = 1'b1;
    checkOutput("doneAfterPlay", {done, move_valid, busy}, 3'b100);
    checkOutput("pathLenDone", path_len, n);
  endtask

  initial begin
    RST = 1'b0; start = 1'b0; move_ready = 1'b0; fs_empty = 1'b1; fs_data = 2'b00;
    #12;
    checkOutput("resetOutputs", {fs_pop, move_valid, Move, path_len, busy, done, ovf}, 0);
    @(negedge clk);
    RST = 1'b1;

    // Stack top-first 11,10,01,00 replays as 00,01,10,11.
    stack = {2'b00, 2'b01, 2'b10, 2'b11};
    fs_empty = 1'b0;
    applyStimulus(0, 1'b0, -1);

    applyStimulus(0, 1'b0, -1);

    loadStack(3);
    applyStimulus(1, 1'b0, -1);

    // Overflow, then a restart from ERR drains what is left on the stack.
    loadStack(DEPTH + 1 + $urandom_range(0, 2));
    applyStimulus(2, 1'b0, -1);
    applyStimulus(2, 1'b0, -1);

    // Start held high through DONE must not trigger another replay.
    loadStack(2);
    applyStimulus(0, 1'b1, -1);
    loadStack(2);
    popCount = 0;
    repeat (5) tick();
    checkOutput("holdNoRestart", {done, busy}, 2'b10);
    checkOutput("holdNoPops", popCount, 0);
    applyStimulus(2, 1'b0, -1);

    // Asynchronous reset in the middle of playback.
    stack.delete();
    loadStack(4);
    applyStimulus(0, 1'b0, 2);
    #2 RST = 1'b0;
    #1 checkOutput("asyncReset", {fs_pop, move_valid, Move, path_len, busy, done, ovf}, 0);
    tick();
    tick();
    RST = 1'b1;
    loadStack(3);
    popCount = 0;
    repeat (5) tick();
    checkOutput("idleAfterReset", {busy, done, ovf}, 3'b000);
    checkOutput("noPopAfterReset", popCount, 0);
    applyStimulus(2, 1'b0, -1);

    for (int i = 0; i < 8; i++) begin
      loadStack($urandom_range(0, DEPTH));
      applyStimulus($urandom_range(0, 2), 1'b0, -1);
    end

    checkOutput("protocolViolations", violations, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maze_path_player.md
Name: maze_path_player

Overview:
- Replays the solved rat-in-maze path after the solver controller asserts Run.
- Drains the solver's direction stack (top = most recent move) into an internal LIFO buffer, which reverses the order.
- Then emits the moves in original order, start cell to goal, one per valid/ready handshake, to the display/motion side.
- Reports path length, completion and buffer overflow.

Parameters:
- DEPTH, 256, capacity of the internal move buffer in entries.
- LEN_W, 9, width of the buffer pointer and path_len. Must satisfy 2^LEN_W > DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- start  input  1  level; a rising edge sampled in IDLE, DONE or ERR begins a new replay. Ignored while busy.
- fs_empty  input  1  direction stack is empty.
- fs_data  input  2  direction popped from the stack; valid the cycle after fs_pop.
- fs_pop  output  1  one-cycle pop request to the direction stack.
- move_valid  output  1  Move holds a valid direction.
- move_ready  input  1  consumer accepts Move this cycle.
- Move  output  2  direction: 00 up, 01 right, 10 left, 11 down.
- path_len  output  LEN_W  number of moves captured in the current replay.
- busy  output  1  high in POP, CAPTURE and PLAY.
- done  output  1  high in DONE.
- ovf  output  1  high in ERR.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; wr_ptr=0; start_q=0.
  - All outputs 0: fs_pop, move_valid, Move, path_len, busy, done, ovf.
  - Buffer contents are don't-care.
  - Reset mid-operation abandons the replay with no further fs_pop. Entries already popped are lost.
- start_q is a registered copy of start. start_rise = start & ~start_q.
- States: IDLE, POP, CAPTURE, PLAY, DONE, ERR.
- IDLE: on start_rise → POP, clear wr_ptr.
- DONE / ERR: on start_rise → POP, clear wr_ptr, clear ovf/done.
- POP: depends on fs_empty and wr_ptr.
  - fs_empty=1, wr_ptr=0 → DONE (empty path).
  - fs_empty=1, wr_ptr>0 → PLAY.
  - fs_empty=0, wr_ptr==DEPTH → ERR. fs_pop stays low.
  - Otherwise fs_pop=1 for this single cycle, then → CAPTURE.
- CAPTURE: buf[wr_ptr]<=fs_data; wr_ptr<=wr_ptr+1; → POP.
  - Each entry costs 2 cycles.
  - A path of N moves reaches PLAY 2N+1 cycles after the cycle start_rise is sampled.
- PLAY:
  - move_valid=1; Move=buf[wr_ptr-1].
  - On move_ready=1, wr_ptr decrements. If wr_ptr was 1 → DONE, else stay in PLAY.
  - Move must stay stable while move_valid=1 and move_ready=0.
  - move_ready is ignored outside PLAY.
- path_len:
  - Loaded with wr_ptr on the POP→PLAY/DONE/ERR transition, and holds through PLAY and DONE.
  - Shows DEPTH in ERR.
  - Cleared when a new replay starts.
- Move=00 whenever move_valid=0.
- fs_pop is never asserted in any state other than POP, and never while fs_empty=1.
- Order: the stack yields moves last-first. The buffer stores them in pop order (index 0 = last move). PLAY reads from the top, so the first move of the path is emitted first.
- start held high across DONE does not restart; a fresh rising edge is required.
- A start edge during POP, CAPTURE or PLAY is ignored, and start_q still tracks start.

Test Plan:
- Stack preloaded top-first 11,10,01,00, start pulse:
  - Exactly 4 fs_pop pulses, spaced 2 cycles.
  - PLAY 9 cycles after start is sampled; path_len=4.
  - Move sequence 00,01,10,11 with move_ready=1 every cycle.
  - done=1 after the 4th handshake.
- fs_empty=1 at start → DONE on the 2nd cycle; path_len=0; fs_pop never high; move_valid never high.
- Backpressure: 3-entry path, move_ready toggling 0,0,1 → each Move holds for 3 cycles with move_valid=1, and order is preserved.
- DEPTH=4 build, stack holding 5 entries → 4 pops, then ERR with ovf=1, path_len=4, fs_pop low. A start re-edge restarts from POP.
- RST low during PLAY after 2 of 4 moves → all outputs 0 immediately, without waiting for a clock edge. After release, state is IDLE and no fs_pop occurs until start_rise.
- start held high after DONE → no restart. Dropping start and raising it again → new replay begins and done clears.
